// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: PC, single-outstanding req/valid instruction memory port,
// IF/ID register with skid buffer, branch redirect/flush, and sign-extender control decode.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [63:0] BranchTarget,
    output logic        IMemReq,
    output logic [63:0] IMemAddr,
    input  logic [31:0] IMemRdata,
    input  logic        IMemValid,
    output logic        IfIdValid,
    output logic [63:0] IfIdPC,
    output logic [31:0] IfIdInstr,
    output logic [25:0] Imm26,
    output logic [1:0]  SignOp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic        squash;
    logic [31:0] skid;

    assign IMemReq  = (state == REQ);
    assign IMemAddr = pc;
    assign Imm26    = IfIdInstr[25:0];

    // NOTE: non-blocking assignments throughout; where a later statement in this block
    // assigns the same register again (branch redirect, IF/ID load), the later one wins.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            squash    <= 1'b0;
            skid      <= '0;
            IfIdValid <= 1'b0;
            IfIdPC    <= '0;
            IfIdInstr <= '0;
        end else begin
            if (!Stall)
                IfIdValid <= 1'b0;

            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    state  <= WAIT;
                    squash <= BranchTaken;
                end
                WAIT: begin
                    if (IMemValid) begin
                        state  <= REQ;
                        squash <= 1'b0;
                        if (!squash && !BranchTaken) begin
                            if (!Stall || !IfIdValid) begin
                                IfIdValid <= 1'b1;
                                IfIdPC    <= pc;
                                IfIdInstr <= IMemRdata;
                                pc        <= pc + 64'd4;
                            end else begin
                                // decode is holding IF/ID, so park the word until it lets go
                                skid  <= IMemRdata;
                                state <= HOLD;
                            end
                        end
                    end else if (BranchTaken) begin
                        squash <= 1'b1;
                    end
                end
                HOLD: begin
                    if (BranchTaken) begin
                        state <= REQ;
                    end else if (!Stall) begin
                        IfIdValid <= 1'b1;
                        IfIdPC    <= pc;
                        IfIdInstr <= skid;
                        pc        <= pc + 64'd4;
                        state     <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase

            // redirect overrides any PC advance and flushes IF/ID even under stall
            if (BranchTaken) begin
                pc        <= BranchTarget;
                IfIdValid <= 1'b0;
            end
        end
    end

    // NOTE: SignOp gets a default before the priority chain so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    always_comb begin
        SignOp = 2'b00;
        if (IfIdInstr[30:26] == 5'b00101)
            SignOp = 2'b10;
        else if (IfIdInstr[31:25] == 7'b1011010 || IfIdInstr[31:24] == 8'h54)
            SignOp = 2'b11;
        else if (IfIdInstr[31:21] == 11'h7C0 || IfIdInstr[31:21] == 11'h7C2)
            SignOp = 2'b01;
    end

endmodule
